fp_mul_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides.
- Successor to the team's combinational single-precision multiplier, adding:
  - configurable exponent and fraction widths
  - round-to-nearest-even
  - special-value handling (NaN/Inf/zero/denormal)
  - exception flags
  - backpressure
- Sits between an operand issue stage and the FPU writeback.

---
 rtl/fp_mul_pipe.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754-style multiplier: unpack/multiply, normalise/round-nearest-even, pack/special.
// Denormal operands are flushed to zero; the whole pipe stalls only when the output is held.
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int W      = 1 + EXP_W + FRAC_W
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] Out,
  output logic [3:0]   Flags
);

  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ZERO_S  = '0;

  logic advance;

  // ---------------- S1: unpack / classify / multiply ----------------
  logic                sa, sb;
  logic [EXP_W-1:0]    ea, eb;
  logic [FRAC_W-1:0]   fa, fb;
  logic                za, zb, ia, ib, na, nb;

  logic                v1_q;
  logic                sign1_q, sign1_d;
  logic                nan1_q, nan1_d;
  logic                inf1_q, inf1_d;
  logic                zero1_q, zero1_d;
  logic [PW-1:0]       prod1_q, prod1_d;
  logic signed [XW-1:0] exp1_q, exp1_d;

  assign advance = !(OutValid && !OutReady);
  assign InReady = advance;

  always_comb begin
    {sa, ea, fa} = InA;
    {sb, eb, fb} = InB;
    za = (ea == '0);
    zb = (eb == '0);
    ia = (ea == '1) && (fa == '0);
    ib = (eb == '1) && (fb == '0);
    na = (ea == '1) && (fa != '0);
    nb = (eb == '1) && (fb != '0);
    sign1_d = sa ^ sb;
    nan1_d  = na || nb || (ia && zb) || (ib && za);
    inf1_d  = ia || ib;
    zero1_d = za || zb;
    prod1_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
    exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      nan1_q  <= 1'b0;
      inf1_q  <= 1'b0;
      zero1_q <= 1'b0;
      prod1_q <= '0;
      exp1_q  <= '0;
    end else if (advance) begin
      v1_q <= InValid;
      if (InValid) begin
        sign1_q <= sign1_d;
        nan1_q  <= nan1_d;
        inf1_q  <= inf1_d;
        zero1_q <= zero1_d;
        prod1_q <= prod1_d;
        exp1_q  <= exp1_d;
      end
    end
  end

  // ---------------- S2: normalise / round ----------------
  logic                 msb, guard, sticky, rnd, carry;
  logic [FRAC_W-1:0]    frac_t, frac2_d;

  logic                 v2_q;
  logic                 sign2_q, nan2_q, inf2_q, zero2_q;
  logic [FRAC_W-1:0]    frac2_q;
  logic signed [XW-1:0] exp2_q, exp2_d;
  logic                 inexact2_q, inexact2_d;

  // Product lies in [1,4); bit PW-1 selects which window holds the fraction.
  always_comb begin
    msb    = prod1_q[PW-1];
    frac_t = msb ? prod1_q[PW-2 -: FRAC_W] : prod1_q[PW-3 -: FRAC_W];
    guard  = msb ? prod1_q[FRAC_W]         : prod1_q[FRAC_W-1];
    sticky = msb ? |prod1_q[FRAC_W-1:0]    : |prod1_q[FRAC_W-2:0];
    rnd    = guard && (sticky || frac_t[0]);
    {carry, frac2_d} = {1'b0, frac_t} + (FRAC_W + 1)'(rnd);
    exp2_d     = exp1_q + XW'(msb) + XW'(carry);
    inexact2_d = guard || sticky;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v2_q       <= 1'b0;
      sign2_q    <= 1'b0;
      nan2_q     <= 1'b0;
      inf2_q     <= 1'b0;
      zero2_q    <= 1'b0;
      frac2_q    <= '0;
      exp2_q     <= '0;
      inexact2_q <= 1'b0;
    end else if (advance) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sign2_q    <= sign1_q;
        nan2_q     <= nan1_q;
        inf2_q     <= inf1_q;
        zero2_q    <= zero1_q;
        frac2_q    <= frac2_d;
        exp2_q     <= exp2_d;
        inexact2_q <= inexact2_d;
      end
    end
  end

  // ---------------- S3: pack / special values ----------------
  logic         v3_q;
  logic [W-1:0] out_q, out_d;
  logic [3:0]   flags_q, flags_d;

  always_comb begin
    out_d   = {sign2_q, exp2_q[EXP_W-1:0], frac2_q};
    flags_d = {3'b000, inexact2_q};
    if (nan2_q) begin
      out_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};
      flags_d = 4'b1000;
    end else if (inf2_q) begin
      out_d   = {sign2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (zero2_q) begin
      out_d   = {sign2_q, {(W - 1){1'b0}}};
      flags_d = 4'b0000;
    end else if (exp2_q >= EXP_MAX) begin
      out_d   = {sign2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp2_q <= ZERO_S) begin
      out_d   = {sign2_q, {(W - 1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v3_q    <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
    end else if (advance) begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_q   <= out_d;
        flags_q <= flags_d;
      end
    end
  end

  assign OutValid = v3_q;
  assign Out      = out_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: FP32 and half-precision instances, directed vectors,
// latency, backpressure and asynchronous reset with results in flight.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        f_iv, f_irdy, f_ov, f_ordy;
  logic [31:0] f_a, f_b, f_out;
  logic [3:0]  f_fl;
  logic        h_iv, h_irdy, h_ov, h_ordy;
  logic [15:0] h_a, h_b, h_out;
  logic [3:0]  h_fl;

  fp_mul_pipe u_f (
    .Clk(clk), .Rst_n(rst_n), .InValid(f_iv), .InReady(f_irdy), .InA(f_a), .InB(f_b),
    .OutValid(f_ov), .OutReady(f_ordy), .Out(f_out), .Flags(f_fl)
  );

  fp_mul_pipe #(.EXP_W(5), .FRAC_W(10)) u_h (
    .Clk(clk), .Rst_n(rst_n), .InValid(h_iv), .InReady(h_irdy), .InA(h_a), .InB(h_b),
    .OutValid(h_ov), .OutReady(h_ordy), .Out(h_out), .Flags(h_fl)
  );

  typedef struct {
    logic [31:0] o;
    logic [3:0]  fl;
    int unsigned acc;
  } exp_t;

  exp_t        fq[$];
  exp_t        hq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc_n = 0;
  int unsigned stall_left = 0;
  bit          lat_chk = 1'b0;
  bit          f_took, h_took;
  logic [31:0] f_nx_o, h_nx_o;
  logic [3:0]  f_nx_fl, h_nx_fl;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock: called just after a falling edge with inputs already set.
  task automatic cyc();
    exp_t e;
    f_ordy = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    f_took = 1'b0;
    h_took = 1'b0;
    #1;
    if (f_ov && !f_ordy) begin
      chk("f_inready_stall", {35'd0, f_irdy}, 36'd0);
      if (fq.size() > 0) chk("f_hold", {f_out, f_fl}, {fq[0].o, fq[0].fl});
    end else begin
      chk("f_inready", {35'd0, f_irdy}, 36'd1);
    end
    if (f_ov && f_ordy) begin
      if (fq.size() == 0) chk("f_spurious", {35'd0, f_ov}, 36'd0);
      else begin
        e = fq.pop_front();
        chk("f_out", {f_out, f_fl}, {e.o, e.fl});
        if (lat_chk) chk("f_latency", 36'(cyc_n - e.acc), 36'd3);
      end
    end
    if (f_iv && f_irdy) begin
      fq.push_back('{f_nx_o, f_nx_fl, cyc_n});
      f_took = 1'b1;
    end
    if (h_ov && h_ordy) begin
      if (hq.size() == 0) chk("h_spurious", {35'd0, h_ov}, 36'd0);
      else begin
        e = hq.pop_front();
        chk("h_out", {16'd0, h_out, h_fl}, {e.o, e.fl});
        chk("h_latency", 36'(cyc_n - e.acc), 36'd3);
      end
    end
    if (h_iv && h_irdy) begin
      hq.push_back('{h_nx_o, h_nx_fl, cyc_n});
      h_took = 1'b1;
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic send_f(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] o, input logic [3:0] fl);
    f_iv = 1'b1; f_a = a; f_b = b; f_nx_o = o; f_nx_fl = fl;
    f_took = 1'b0;
    for (int i = 0; i < 20 && !f_took; i++) cyc();
    chk("f_accept", {35'd0, f_took}, 36'd1);
    f_iv = 1'b0; f_a = $urandom; f_b = $urandom;
  endtask

  task automatic send_h(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] o, input logic [3:0] fl);
    h_iv = 1'b1; h_a = a; h_b = b; h_nx_o = {16'd0, o}; h_nx_fl = fl;
    h_took = 1'b0;
    for (int i = 0; i < 20 && !h_took; i++) cyc();
    chk("h_accept", {35'd0, h_took}, 36'd1);
    h_iv = 1'b0; h_a = 16'($urandom); h_b = 16'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (fq.size() + hq.size()) != 0; i++) cyc();
    chk("drain", 36'(fq.size() + hq.size()), 36'd0);
    repeat (3) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    f_iv = 1'b0; f_a = '0; f_b = '0; f_ordy = 1'b1;
    h_iv = 1'b0; h_a = '0; h_b = '0; h_ordy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_f_valid", {35'd0, f_ov}, 36'd0);
    chk("rst_f_out", {f_out, f_fl}, 36'd0);
    chk("rst_h_out", {15'd0, h_ov, h_out, h_fl}, 36'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_f_inready", {35'd0, f_irdy}, 36'd1);
    @(negedge clk);

    // Isolated product for latency, then a back-to-back directed batch.
    lat_chk = 1'b1;
    send_f(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
    drain();
    send_f(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    send_f(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    send_f(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    send_f(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    send_f(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    send_f(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    send_f(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
    send_f(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
    send_f(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    send_f(32'h00000001, 32'h7F000000, 32'h00000000, 4'b0000);
    send_f(32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000);
    drain();

    send_h(16'h4200, 16'h4000, 16'h4600, 4'b0000);
    send_h(16'h3DA8, 16'h3DA8, 16'h4000, 4'b0001);
    drain();

    // Six back-to-back products with a 4-cycle output stall once the pipe is full.
    lat_chk = 1'b0;
    send_f(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
    send_f(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
    send_f(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    stall_left = 4;
    send_f(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    send_f(32'h3F000000, 32'h3F000000, 32'h3E800000, 4'b0000);
    send_f(32'h3F800000, 32'h12345678, 32'h12345678, 4'b0000);
    drain();

    // Three results in flight (output held), then asynchronous reset between edges.
    stall_left = 100;
    send_f(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
    send_f(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    send_f(32'h3F000000, 32'h3F000000, 32'h3E800000, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {35'd0, f_ov}, 36'd0);
    chk("rst_mid_out", {f_out, f_fl}, 36'd0);
    fq.delete();
    stall_left = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("post_rst_valid", {35'd0, f_ov}, 36'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
